// File: rtl/ov_fifo_frame_reader.sv
// rtl/ov_fifo_frame_reader.sv - OV7670 + AL422 FIFO single-frame capture and pixel readout controller
// Gates one VSYNC-bounded frame into the FIFO, then reads it back as 16-bit pixels on a valid/ready stream.
module ov_fifo_frame_reader #(
    parameter int H_ACTIVE       = 320,
    parameter int V_ACTIVE       = 240,
    parameter int RCLK_HALF      = 2,
    parameter int RRST_CLKS      = 2,
    parameter int BYTE_ORDER     = 0,
    parameter int VS_ACTIVE_HIGH = 1,
    parameter int CNT_W          = 18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INIT_DONE,
    input  logic        START,
    input  logic        CONTINUOUS,
    input  logic        ABORT,
    input  logic        OV_VS,
    input  logic [7:0]  OV_DATA,
    output logic        OV_WREN,
    output logic        OV_WRST,
    output logic        OV_RCLK,
    output logic        OV_RRST,
    output logic [15:0] PIX_DATA,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic        PIX_SOF,
    output logic        PIX_EOL,
    output logic        PIX_EOF,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT
);

    localparam int PH_W = $clog2(2 * RCLK_HALF);
    localparam int RR_W = $clog2(RRST_CLKS + 1);
    localparam int X_W  = $clog2(H_ACTIVE + 1);
    localparam int Y_W  = $clog2(V_ACTIVE + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * RCLK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(RCLK_HALF);
    localparam logic [RR_W-1:0]  RR_LAST   = RR_W'(RRST_CLKS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * H_ACTIVE * V_ACTIVE - 1);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WRST,
        S_WRITE,
        S_RRST,
        S_READ,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic            vs_s1, vs_s2, vs_s3, vs_edge;
    logic            wrst_cnt;
    logic [PH_W-1:0] ph;
    logic [RR_W-1:0] rrst_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic            bytes_done;
    logic [7:0]      hold_byte;
    logic [X_W-1:0]  x_cnt;
    logic [Y_W-1:0]  y_cnt;

    logic rclk_run, period_end, park, sample, xfer, eof_xfer, last_rrst;

    // Two-flop synchroniser; the edge pulse is registered so pin-to-pulse latency is 3 CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_s3   <= 1'b0;
            vs_edge <= 1'b0;
        end else begin
            vs_s1   <= OV_VS;
            vs_s2   <= vs_s1;
            vs_s3   <= vs_s2;
            vs_edge <= (VS_ACTIVE_HIGH != 0) ? (vs_s2 & ~vs_s3) : (~vs_s2 & vs_s3);
        end
    end

    // RCLK period: low half (ph < RCLK_HALF) then high half; the byte is taken at the last high CLK.
    assign xfer       = PIX_VALID && PIX_READY;
    assign eof_xfer   = xfer && PIX_EOF;
    assign period_end = (ph == PH_LAST);
    assign rclk_run   = (state == S_RRST) || ((state == S_READ) && !bytes_done);
    assign park       = (state == S_READ) && period_end && byte_cnt[0] && PIX_VALID && !PIX_READY;
    assign sample     = (state == S_READ) && !bytes_done && period_end && !park;
    assign last_rrst  = (state == S_RRST) && period_end && (rrst_cnt == RR_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (ABORT) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (START && INIT_DONE) state_n = S_ARM;
                S_ARM:   if (vs_edge) state_n = S_WRST;
                S_WRST:  if (wrst_cnt) state_n = S_WRITE;
                S_WRITE: if (vs_edge) state_n = S_RRST;
                S_RRST:  if (last_rrst) state_n = S_READ;
                S_READ:  if (eof_xfer) state_n = S_DONE;
                S_DONE:  state_n = CONTINUOUS ? S_ARM : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign OV_WREN = (state == S_WRITE);
    assign OV_WRST = (state != S_WRST);
    assign OV_RRST = (state != S_RRST);
    assign OV_RCLK = !(rclk_run && (ph < PH_HALF));
    assign BUSY    = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrst_cnt   <= 1'b0;
            ph         <= '0;
            rrst_cnt   <= '0;
            byte_cnt   <= '0;
            bytes_done <= 1'b0;
            hold_byte  <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            PIX_DATA   <= '0;
            PIX_VALID  <= 1'b0;
            PIX_SOF    <= 1'b0;
            PIX_EOL    <= 1'b0;
            PIX_EOF    <= 1'b0;
            FRAME_CNT  <= '0;
        end else begin
            wrst_cnt <= (state == S_WRST) ? ~wrst_cnt : 1'b0;

            if (!rclk_run) begin
                ph <= '0;
            end else if (!park) begin
                ph <= period_end ? '0 : ph + PH_W'(1);
            end

            if (state != S_RRST) begin
                rrst_cnt <= '0;
            end else if (period_end) begin
                rrst_cnt <= rrst_cnt + RR_W'(1);
            end

            if (state == S_RRST) begin
                byte_cnt   <= '0;
                bytes_done <= 1'b0;
                x_cnt      <= '0;
                y_cnt      <= '0;
            end else if (sample) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
                if (byte_cnt == LAST_BYTE) begin
                    bytes_done <= 1'b1;
                end
                if (!byte_cnt[0]) begin
                    hold_byte <= OV_DATA;
                end else if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + Y_W'(1);
                end else begin
                    x_cnt <= x_cnt + X_W'(1);
                end
            end

            // A new pixel may load in the same cycle the previous one drains.
            if (ABORT) begin
                PIX_VALID <= 1'b0;
                PIX_SOF   <= 1'b0;
                PIX_EOL   <= 1'b0;
                PIX_EOF   <= 1'b0;
            end else if (sample && byte_cnt[0]) begin
                PIX_VALID <= 1'b1;
                PIX_DATA  <= (BYTE_ORDER != 0) ? {OV_DATA, hold_byte} : {hold_byte, OV_DATA};
                PIX_SOF   <= (byte_cnt == CNT_W'(1));
                PIX_EOL   <= (x_cnt == X_LAST);
                PIX_EOF   <= (x_cnt == X_LAST) && (y_cnt == Y_LAST);
            end else if (xfer) begin
                PIX_VALID <= 1'b0;
                PIX_SOF   <= 1'b0;
                PIX_EOL   <= 1'b0;
                PIX_EOF   <= 1'b0;
            end

            if ((state == S_READ) && eof_xfer && !ABORT) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ov_fifo_frame_reader.sv
// tb/tb_ov_fifo_frame_reader.sv - directed bench for ov_fifo_frame_reader on a 4x2 frame
module tb_ov_fifo_frame_reader;

    localparam int NPIX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic abort = 1'b0;
    logic ov_vs = 1'b0;
    logic [7:0] ov_data = 8'h00;
    logic pix_ready = 1'b1;

    logic        ov_wren, ov_wrst, ov_rclk, ov_rrst;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy;
    logic [15:0] frame_cnt;

    logic        b_wren, b_wrst, b_rclk, b_rrst;
    logic [15:0] b_data;
    logic        b_valid, b_sof, b_eol, b_eof, b_busy;
    logic [15:0] b_fcnt;

    always #5 clk = ~clk;

    ov_fifo_frame_reader #(
        .H_ACTIVE(4), .V_ACTIVE(2), .RCLK_HALF(2), .RRST_CLKS(2),
        .BYTE_ORDER(0), .VS_ACTIVE_HIGH(1), .CNT_W(8)
    ) u_dut (
        .CLK(clk), .RST(rst), .INIT_DONE(init_done), .START(start),
        .CONTINUOUS(continuous), .ABORT(abort), .OV_VS(ov_vs), .OV_DATA(ov_data),
        .OV_WREN(ov_wren), .OV_WRST(ov_wrst), .OV_RCLK(ov_rclk), .OV_RRST(ov_rrst),
        .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_READY(pix_ready),
        .PIX_SOF(pix_sof), .PIX_EOL(pix_eol), .PIX_EOF(pix_eof),
        .BUSY(busy), .FRAME_CNT(frame_cnt)
    );

    ov_fifo_frame_reader #(
        .H_ACTIVE(4), .V_ACTIVE(2), .RCLK_HALF(2), .RRST_CLKS(2),
        .BYTE_ORDER(1), .VS_ACTIVE_HIGH(1), .CNT_W(8)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .INIT_DONE(init_done), .START(start),
        .CONTINUOUS(continuous), .ABORT(abort), .OV_VS(ov_vs), .OV_DATA(ov_data),
        .OV_WREN(b_wren), .OV_WRST(b_wrst), .OV_RCLK(b_rclk), .OV_RRST(b_rrst),
        .PIX_DATA(b_data), .PIX_VALID(b_valid), .PIX_READY(pix_ready),
        .PIX_SOF(b_sof), .PIX_EOL(b_eol), .PIX_EOF(b_eof),
        .BUSY(b_busy), .FRAME_CNT(b_fcnt)
    );

    int n_tests = 0;
    int n_fail = 0;
    int rdy_div = 1;
    int rdy_phase = 0;
    int byte_k = 0;
    int wrst_low = 0;
    int wren_cnt = 0;
    int rise_cnt = 0;
    int stable_err = 0;
    int stall_cnt = 0;
    int exp_fcnt = 0;
    logic        stall_prev = 1'b0;
    logic [18:0] stall_snap = '0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [2:0]  qm[$];

    // FIFO model: read-reset rewinds to byte 0, each later RCLK rise presents the next byte.
    always @(posedge ov_rclk) begin
        if (!ov_rrst) begin
            byte_k = 0;
        end else begin
            ov_data = byte_k[7:0];
            byte_k++;
        end
    end

    always @(posedge ov_rclk) begin
        if (busy) rise_cnt++;
    end

    always @(posedge clk) begin
        #1;
        rdy_phase = (rdy_phase + 1) % rdy_div;
        pix_ready = (rdy_phase == 0);
    end

    always @(negedge clk) begin
        if (!ov_wrst) wrst_low++;
        if (ov_wren) wren_cnt++;
        if (stall_prev && pix_valid && ({pix_data, pix_sof, pix_eol, pix_eof} !== stall_snap)) stable_err++;
        stall_prev = pix_valid && !pix_ready;
        stall_snap = {pix_data, pix_sof, pix_eol, pix_eof};
        if (stall_prev) stall_cnt++;
        if (pix_valid && pix_ready) begin
            qa.push_back(pix_data);
            qm.push_back({pix_sof, pix_eol, pix_eof});
        end
        if (b_valid && pix_ready) qb.push_back(b_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic vs_pulse();
        ov_vs = 1'b1;
        repeat (2) cyc();
        ov_vs = 1'b0;
        repeat (2) cyc();
    endtask

    // Second VSYNC rise lands 20 CLK after the first.
    task automatic run_frame();
        start_pulse();
        repeat (2) cyc();
        vs_pulse();
        repeat (16) cyc();
        vs_pulse();
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_fcnt(input string tag, input int target, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (frame_cnt != 16'(target) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_cnt, target);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {ov_wren, ov_wrst, ov_rclk, ov_rrst, pix_valid, pix_sof, pix_eol, pix_eof, busy},
              9'b0_1_1_1_0_0_0_0_0);
        check({tag, "_data"}, pix_data, 0);
        check({tag, "_fcnt"}, frame_cnt, 0);
    endtask

    task automatic check_pixels(input string tag, input int bi, input logic order_b);
        logic [15:0] got, exp;
        logic [7:0]  sof_v, eol_v, eof_v;
        sof_v = '0;
        eol_v = '0;
        eof_v = '0;
        for (int i = 0; i < NPIX; i++) begin
            exp = order_b ? {8'(2 * i + 1), 8'(2 * i)} : {8'(2 * i), 8'(2 * i + 1)};
            if (order_b) got = (bi + i < qb.size()) ? qb[bi + i] : 16'hFFFF;
            else         got = (bi + i < qa.size()) ? qa[bi + i] : 16'hFFFF;
            check($sformatf("%s_pix%0d", tag, i), got, exp);
            if (!order_b && (bi + i < qm.size())) {sof_v[i], eol_v[i], eof_v[i]} = qm[bi + i];
        end
        if (!order_b) begin
            check({tag, "_sof"}, sof_v, 8'h01);
            check({tag, "_eol"}, eol_v, 8'h88);
            check({tag, "_eof"}, eof_v, 8'h80);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ba, bb, w0, e0, r0, s0, st0;

        repeat (3) cyc();
        check_reset("rst");
        rst = 1'b0;
        init_done = 1'b1;
        cyc();

        // Basic frame, both byte orders.
        ba = qa.size(); bb = qb.size(); w0 = wrst_low; e0 = wren_cnt; r0 = rise_cnt;
        run_frame();
        wait_idle("t1_idle", 400);
        exp_fcnt++;
        check("t1_wrst_low", wrst_low - w0, 2);
        check("t1_wren_cycles", wren_cnt - e0, 18);
        check("t1_rclk_rises", rise_cnt - r0, 18);
        check("t1_npix", qa.size() - ba, NPIX);
        check_pixels("t1", ba, 1'b0);
        check_pixels("t2", bb, 1'b1);
        check("t1_fcnt", frame_cnt, exp_fcnt);
        check("t1_busy", busy, 0);

        // Backpressure 1 on / 3 off, then 1 on / 15 off to force RCLK parking.
        for (int pass = 0; pass < 2; pass++) begin
            rdy_div = (pass == 0) ? 4 : 16;
            ba = qa.size(); r0 = rise_cnt; s0 = stable_err; st0 = stall_cnt;
            run_frame();
            wait_idle($sformatf("t3_%0d_idle", pass), 800);
            exp_fcnt++;
            check($sformatf("t3_%0d_npix", pass), qa.size() - ba, NPIX);
            check_pixels($sformatf("t3_%0d", pass), ba, 1'b0);
            check($sformatf("t3_%0d_stable", pass), stable_err - s0, 0);
            check($sformatf("t3_%0d_stalled", pass), (stall_cnt - st0) > 0, 1);
            check($sformatf("t3_%0d_rclk_rises", pass), rise_cnt - r0, 18);
            check($sformatf("t3_%0d_fcnt", pass), frame_cnt, exp_fcnt);
        end
        rdy_div = 1;
        repeat (2) cyc();

        // Continuous: third VSYNC arrives mid-read and must be dropped.
        continuous = 1'b1;
        ba = qa.size();
        run_frame();
        repeat (20) cyc();
        vs_pulse();
        exp_fcnt++;
        wait_fcnt("t4_frame1", exp_fcnt, 400);
        vs_pulse();
        repeat (16) cyc();
        vs_pulse();
        exp_fcnt++;
        wait_fcnt("t4_frame2", exp_fcnt, 400);
        repeat (3) cyc();
        check("t4_busy_arm", busy, 1);
        check("t4_npix", qa.size() - ba, 2 * NPIX);
        check_pixels("t4_f1", ba, 1'b0);
        check_pixels("t4_f2", ba + NPIX, 1'b0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        continuous = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_fcnt", frame_cnt, exp_fcnt);

        // Abort during WRITE, then START without INIT_DONE.
        start_pulse();
        repeat (2) cyc();
        vs_pulse();
        repeat (5) cyc();
        check("t5_wren_on", ov_wren, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_wren_off", ov_wren, 0);
        check("t5_busy", busy, 0);
        check("t5_fcnt_kept", frame_cnt, exp_fcnt);
        init_done = 1'b0;
        start_pulse();
        repeat (3) cyc();
        check("t5_start_ignored", busy, 0);

        // Reset mid-read.
        init_done = 1'b1;
        ba = qa.size();
        run_frame();
        begin
            int n;
            n = 0;
            while (qa.size() - ba < 3 && n < 300) begin
                cyc();
                n++;
            end
        end
        check("t6_mid_read", (qa.size() - ba) >= 3, 1);
        rst = 1'b1;
        cyc();
        check_reset("t6");
        rst = 1'b0;
        repeat (2) cyc();
        check("t6_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
